// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        CORE  = 1'b0,
        DEBUG = 1'b1
    } req_id_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way selector: debug has strict priority while the core is halted,
// otherwise contention alternates based on the previous winner.
module dmem_rr_pick
    import dmem_pkg::*;
(
    input  logic       [1:0] reqs,        // bit 0 = core, bit 1 = debug
    input  logic             dbg_halted,
    input  req_id_t          last_winner,
    output logic       [1:0] grant        // one-hot, same bit order as reqs
);

    // Combinational pick of at most one requester.
    always_comb begin
        grant = 2'b00;
        if (dbg_halted) begin
            // A halted core is never served; only the debug port may win.
            grant = {reqs[1], 1'b0};
        end else if (reqs[0] && reqs[1]) begin
            grant = (last_winner == DEBUG) ? 2'b01 : 2'b10;
        end else if (reqs[0]) begin
            grant = 2'b01;
        end else if (reqs[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and debug ports onto a single-ported data memory.
// One transaction takes two cycles: grant in IDLE, memory access in ACCESS;
// the response is registered at the end of ACCESS.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    input  logic        dbg_halted,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] write_data,
    input  logic [31:0] mem_out
);

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t              state_reg;
    req_id_t             last_winner_reg;
    req_id_t             cmd_id_reg;
    logic                cmd_we_reg;
    logic                cmd_err_reg;
    logic [WORD_W-1:0]   cmd_addr_reg;
    logic [WORD_W-1:0]   cmd_wdata_reg;

    logic [1:0]          reqs;
    logic [1:0]          pick;
    logic [1:0]          grant;
    req_id_t             win_id;
    logic                win_we;
    logic [WORD_W-1:0]   win_addr;
    logic [WORD_W-1:0]   win_wdata;
    logic                win_err;
    logic                access_live;

    logic                rvalid_reg [2];
    logic                err_reg    [2];
    logic [WORD_W-1:0]   rdata_reg  [2];

    assign reqs = {d_req, c_req};

    dmem_rr_pick u_pick (
        .reqs        (reqs),
        .dbg_halted  (dbg_halted),
        .last_winner (last_winner_reg),
        .grant       (pick)
    );

    // Grants only exist in IDLE and never while reset is held.
    assign grant = (state_reg == IDLE && !rst) ? pick : 2'b00;
    assign c_gnt = grant[0];
    assign d_gnt = grant[1];

    assign win_id    = grant[1] ? DEBUG : CORE;
    assign win_we    = grant[1] ? d_we    : c_we;
    assign win_addr  = grant[1] ? d_addr  : c_addr;
    assign win_wdata = grant[1] ? d_wdata : c_wdata;
    // Misaligned or out-of-range accesses never reach the memory.
    assign win_err   = (win_addr[1:0] != 2'b00) || (win_addr[31:2] >= MEM_WORDS_W);

    // Memory is only driven in a live ACCESS cycle; a reset in ACCESS kills it.
    assign access_live = (state_reg == ACCESS) && !rst;
    assign mem_read    = access_live && !cmd_we_reg && !cmd_err_reg;
    assign mem_write   = access_live &&  cmd_we_reg && !cmd_err_reg;
    assign mem_addr    = access_live ? {2'b00, cmd_addr_reg[31:2]} : '0;
    assign write_data  = access_live ? cmd_wdata_reg : '0;

    // Arbitration FSM: capture the winner's command at the grant edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_winner_reg <= DEBUG;
            cmd_id_reg      <= CORE;
            cmd_we_reg      <= 1'b0;
            cmd_err_reg     <= 1'b0;
            cmd_addr_reg    <= '0;
            cmd_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant != 2'b00) begin
                        cmd_id_reg      <= win_id;
                        cmd_we_reg      <= win_we;
                        cmd_err_reg     <= win_err;
                        cmd_addr_reg    <= win_addr;
                        cmd_wdata_reg   <= win_wdata;
                        last_winner_reg <= win_id;
                        state_reg       <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Per-port response registers: one-cycle rvalid, rdata held until the next response.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam logic PORT_BIT = (gi == 1);

        // Register the response of the access that completes this cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_reg[gi] <= 1'b0;
                err_reg[gi]    <= 1'b0;
                rdata_reg[gi]  <= '0;
            end else if (state_reg == ACCESS && cmd_id_reg == req_id_t'(PORT_BIT)) begin
                rvalid_reg[gi] <= 1'b1;
                err_reg[gi]    <= cmd_err_reg;
                rdata_reg[gi]  <= (cmd_err_reg || cmd_we_reg) ? '0 : mem_out;
            end else begin
                rvalid_reg[gi] <= 1'b0;
                err_reg[gi]    <= 1'b0;
            end
        end
    end

    assign c_rvalid = rvalid_reg[0];
    assign c_err    = err_reg[0];
    assign c_rdata  = rdata_reg[0];
    assign d_rvalid = rvalid_reg[1];
    assign d_err    = err_reg[1];
    assign d_rdata  = rdata_reg[1];

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 32: depth of the attached data memory in 32-bit words; power of two.
REQ-002 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-003 Port rst  in  1: reset, synchronous and active-high.
REQ-004 Ports c_req/c_we  in  1/1: core request and write-enable.
REQ-005 Ports c_addr/c_wdata  in  32/32: core byte address and write data.
REQ-006 Ports c_gnt/c_rvalid/c_err  out  1/1/1: core grant, response valid and error.
REQ-007 Port c_rdata  out  32: core read data.
REQ-008 Ports d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_err, d_rdata: the debug-port equivalents of REQ-004..REQ-007, with identical widths.
REQ-009 Port dbg_halted  in  1: the core is halted by the debugger.
REQ-010 Ports mem_read/mem_write  out  1/1: memory strobes.
REQ-011 Ports mem_addr/write_data  out  32/32: memory word index and write data.
REQ-012 Port mem_out  in  32: combinational read data from the memory.

Function
REQ-013 The FSM SHALL have two states: IDLE and ACCESS.
REQ-014 In IDLE, with at least one req high, exactly one gnt SHALL be driven high combinationally in that cycle, and the FSM SHALL move to ACCESS at the next edge.
REQ-015 At the grant edge, the winner's we, addr and wdata and its requester id SHALL be captured into command registers; the requester holds its inputs stable until gnt.
REQ-016 In ACCESS, the memory SHALL be driven from the command registers for exactly one cycle, with mem_addr = {2'b0, addr[31:2]}.
REQ-017 mem_read SHALL equal ~we in ACCESS, and mem_write SHALL equal we in ACCESS.
REQ-018 Outside ACCESS, mem_read, mem_write, mem_addr and write_data SHALL all be 0.
REQ-019 At the end of ACCESS, the FSM SHALL return to IDLE.
REQ-020 The granted port's rvalid SHALL pulse for one cycle, two cycles after its gnt.
REQ-021 rdata SHALL be registered mem_out for reads, and 0 for writes.
REQ-022 rdata SHALL hold its value until the next response to that port.
REQ-023 No gnt SHALL be asserted while in ACCESS; peak throughput is one transaction per 2 cycles.
REQ-024 An access is an error when addr[1:0] != 0 or addr[31:2] >= MEM_WORDS.
REQ-025 On an error, ACCESS SHALL keep both mem strobes at 0, and the response SHALL carry err=1 and rdata=0.
REQ-026 err SHALL be valid only with rvalid, and 0 otherwise.
REQ-027 With dbg_halted=1, the debug port SHALL have strict priority, and c_gnt SHALL stay 0.
REQ-028 With dbg_halted=0 and both reqs high, the port not granted last SHALL win.
REQ-029 A 1-bit last_winner register SHALL be updated on every grant.
REQ-030 A single requester SHALL be granted regardless of last_winner.
REQ-031 A change of dbg_halted while in ACCESS SHALL NOT abort the access in progress; it affects the next arbitration only.

Reset
REQ-032 While rst is high at a clock edge, the FSM SHALL go to IDLE.
REQ-033 At that edge, all gnt, rvalid and err outputs, all rdata outputs, all mem outputs and the command registers SHALL clear to 0.
REQ-034 At that edge, last_winner SHALL be set to DEBUG, so the core wins the first contention.
REQ-035 A reset asserted during ACCESS SHALL suppress that cycle's memory strobes.
REQ-036 A reset asserted during ACCESS SHALL cause no rvalid to be generated for the suppressed access.
REQ-037 gnt SHALL be 0 in any cycle in which rst is high.

Structure
REQ-038 A shared package dmem_pkg SHALL hold the state enum (IDLE, ACCESS), the requester id enum (CORE, DEBUG) and the word-width constant.
REQ-039 One sub-module SHALL be used: dmem_rr_pick, the two-way priority/round-robin selector (inputs: reqs, dbg_halted, last_winner; outputs: one-hot grant).
REQ-040 The total RTL SHALL be 150-250 lines.

Verification
REQ-041 The bench SHALL cover: core write addr 0x30, data 0xDEADBEEF, then core read 0x30 -> mem_write=1 and mem_addr=12 in cycle 2; read rvalid in cycle 6 with rdata 0xDEADBEEF, err=0.
REQ-042 The bench SHALL cover: both reqs held high for 8 cycles with dbg_halted=0 -> grants alternate C,D,C,D; the first grant goes to core after reset.
REQ-043 The bench SHALL cover: both reqs high with dbg_halted=1 -> only d_gnt is asserted; c_gnt=0 throughout, and the core is served once dbg_halted drops.
REQ-044 The bench SHALL cover: debug read at addr 0x80 (word 32) and at addr 0x06 -> no mem strobes; d_rvalid with d_err=1 and d_rdata=0.
REQ-045 The bench SHALL cover: rst asserted in the ACCESS cycle of a core write to 0x10 -> no mem_write, no c_rvalid, and memory word 4 unchanged.
REQ-046 The bench SHALL cover: a debug write followed by a core read of the same address in back-to-back transactions -> the core reads the debug-written value.
